// File: rtl/matrix_alu_p_pkg.sv
// Shared opcodes, FSM encoding and default size limits for the matrix ALU.
package matrix_alu_p_pkg;
  localparam logic [2:0] OP_TRANS = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SMUL  = 3'd2;
  localparam logic [2:0] OP_MMUL  = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_EMUL  = 3'd5;

  localparam int DEF_MAX_ROWS = 5;
  localparam int DEF_MAX_COLS = 5;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_EXEC, S_DONE} state_t;
endpackage

// File: rtl/matrix_alu_p_if.sv
// Request, operand-read and result-write bundle for matrix_alu_p.
interface matrix_alu_p_if #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 4
);
  logic                     start, abort;
  logic [2:0]               op;
  logic [DIM_W-1:0]         dim_m, dim_n, dim_p;
  logic signed [DATA_W-1:0] scalar_k, data_a, data_b;
  logic [DIM_W-1:0]         row_read_a, col_read_a, row_read_b, col_read_b;
  logic [DIM_W-1:0]         row_write, col_write;
  logic signed [DATA_W-1:0] result;
  logic                     result_we, elem_ovf, ovf_sticky, busy, done, err;

  modport master (
    output start, abort, op, dim_m, dim_n, dim_p, scalar_k, data_a, data_b,
    input  row_read_a, col_read_a, row_read_b, col_read_b, row_write, col_write,
           result, result_we, elem_ovf, ovf_sticky, busy, done, err
  );
  modport slave (
    input  start, abort, op, dim_m, dim_n, dim_p, scalar_k, data_a, data_b,
    output row_read_a, col_read_a, row_read_b, col_read_b, row_write, col_write,
           result, result_we, elem_ovf, ovf_sticky, busy, done, err
  );
endinterface

// File: rtl/matrix_alu_p_sat_narrow.sv
// Narrows a wide signed value to DATA_W bits, saturating or wrapping on overflow.
module sat_narrow #(
  parameter int IN_W   = 68,
  parameter int DATA_W = 32,
  parameter int SAT_EN = 1
) (
  input  logic signed [IN_W-1:0]   din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     ovf
);
  // Value fits only if every bit from the DATA_W sign bit upward matches.
  logic [IN_W-DATA_W:0] top;
  assign top = din[IN_W-1:DATA_W-1];
  assign ovf = !((&top) || !(|top));

  always_comb begin
    dout = din[DATA_W-1:0];
    if (SAT_EN != 0 && ovf)
      dout = din[IN_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
endmodule

// File: rtl/matrix_alu_p.sv
// Sequential matrix ALU: one operand read per ADDR/EXEC pair, one element written per strobe.
module matrix_alu_p
  import matrix_alu_p_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DIM_W    = 4,
  parameter int MAX_ROWS = DEF_MAX_ROWS,
  parameter int MAX_COLS = DEF_MAX_COLS,
  parameter int SAT_EN   = 1
) (
  input logic           clk,
  input logic           rst,
  matrix_alu_p_if.slave bus
);
  localparam int ACC_W = 2*DATA_W + DIM_W;
  localparam logic [DIM_W:0] MAX_R = (DIM_W+1)'(MAX_ROWS);
  localparam logic [DIM_W:0] MAX_C = (DIM_W+1)'(MAX_COLS);

  state_t                   state;
  logic [2:0]               op_q;
  logic [DIM_W-1:0]         m_q, n_q, p_q, i_q, j_q, k_q;
  logic signed [DATA_W-1:0] k_sc;
  logic signed [ACC_W-1:0]  acc;
  logic                     first;

  logic signed [ACC_W-1:0]  a_x, b_x, k_x, val;
  logic signed [DATA_W-1:0] nar;
  logic                     nar_ovf, bad, k_more;
  logic [DIM_W-1:0]         last_i, last_j;

  assign bus.row_read_a = i_q;
  assign bus.col_read_a = (op_q == OP_MMUL) ? k_q : j_q;
  assign bus.row_read_b = (op_q == OP_MMUL) ? k_q : i_q;
  assign bus.col_read_b = j_q;

  // All arithmetic at accumulator width so nothing wraps before narrowing.
  assign a_x = ACC_W'($signed(bus.data_a));
  assign b_x = ACC_W'($signed(bus.data_b));
  assign k_x = ACC_W'(k_sc);

  always_comb begin
    val = a_x;
    case (op_q)
      OP_ADD:  val = a_x + b_x;
      OP_SMUL: val = a_x * k_x;
      OP_MMUL: val = acc + a_x * b_x;
      OP_SUB:  val = a_x - b_x;
      OP_EMUL: val = a_x * b_x;
      default: val = a_x;
    endcase
  end

  sat_narrow #(.IN_W(ACC_W), .DATA_W(DATA_W), .SAT_EN(SAT_EN)) u_sat (
    .din(val), .dout(nar), .ovf(nar_ovf)
  );

  assign last_i = m_q - DIM_W'(1);
  assign last_j = ((op_q == OP_MMUL) ? p_q : n_q) - DIM_W'(1);
  assign k_more = ({1'b0, k_q} + (DIM_W+1)'(1)) < {1'b0, n_q};

  always_comb begin
    bad = (op_q > OP_EMUL) || (m_q == '0) || (n_q == '0) ||
          ({1'b0, m_q} > MAX_R) || ({1'b0, n_q} > MAX_C);
    if (op_q == OP_MMUL && (p_q == '0 || {1'b0, p_q} > MAX_C)) bad = 1'b1;
    if (op_q == OP_TRANS && ({1'b0, n_q} > MAX_R || {1'b0, m_q} > MAX_C)) bad = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= '0;
      m_q            <= '0;
      n_q            <= '0;
      p_q            <= '0;
      i_q            <= '0;
      j_q            <= '0;
      k_q            <= '0;
      k_sc           <= '0;
      acc            <= '0;
      first          <= 1'b0;
      bus.result     <= '0;
      bus.row_write  <= '0;
      bus.col_write  <= '0;
      bus.result_we  <= 1'b0;
      bus.elem_ovf   <= 1'b0;
      bus.ovf_sticky <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.result_we <= 1'b0;
      bus.elem_ovf  <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          op_q           <= bus.op;
          m_q            <= bus.dim_m;
          n_q            <= bus.dim_n;
          p_q            <= bus.dim_p;
          k_sc           <= bus.scalar_k;
          i_q            <= '0;
          j_q            <= '0;
          k_q            <= '0;
          acc            <= '0;
          bus.ovf_sticky <= 1'b0;
          bus.err        <= 1'b0;
          bus.busy       <= 1'b1;
          first          <= 1'b1;
          state          <= S_ADDR;
        end
        S_ADDR: begin
          first <= 1'b0;
          if (bus.abort || (first && bad)) begin
            bus.err <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.abort) begin
            bus.err <= 1'b1;
            state   <= S_DONE;
          end else if (op_q == OP_MMUL && k_more) begin
            acc   <= val;
            k_q   <= k_q + DIM_W'(1);
            state <= S_ADDR;
          end else begin
            bus.result_we <= 1'b1;
            bus.result    <= nar;
            bus.elem_ovf  <= nar_ovf;
            if (nar_ovf) bus.ovf_sticky <= 1'b1;
            bus.row_write <= (op_q == OP_TRANS) ? j_q : i_q;
            bus.col_write <= (op_q == OP_TRANS) ? i_q : j_q;
            acc           <= '0;
            k_q           <= '0;
            state         <= S_ADDR;
            if (j_q == last_j) begin
              j_q <= '0;
              if (i_q == last_i) state <= S_DONE;
              else               i_q   <= i_q + DIM_W'(1);
            end else begin
              j_q <= j_q + DIM_W'(1);
            end
          end
        end
        S_DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_alu_p.sv
// Directed bench for matrix_alu_p: stimulus pushes expected writes/done into queues, a monitor pops and compares.
module tb_matrix_alu_p;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_alu_p_if #(.DATA_W(32), .DIM_W(4)) b1 ();
  matrix_alu_p_if #(.DATA_W(32), .DIM_W(4)) b0 ();

  matrix_alu_p #(.SAT_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  matrix_alu_p #(.SAT_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  logic        start, abort, en0, end_req;
  logic [2:0]  op_r;
  logic [3:0]  dm, dn, dp;
  logic [31:0] sk;
  logic signed [31:0] ma [16][16];
  logic signed [31:0] mb [16][16];

  assign b1.start = start;        assign b0.start = start & en0;
  assign b1.abort = abort;        assign b0.abort = abort;
  assign b1.op = op_r;            assign b0.op = op_r;
  assign b1.dim_m = dm;           assign b0.dim_m = dm;
  assign b1.dim_n = dn;           assign b0.dim_n = dn;
  assign b1.dim_p = dp;           assign b0.dim_p = dp;
  assign b1.scalar_k = sk;        assign b0.scalar_k = sk;

  // Operand memories answer one cycle after the address is presented.
  always @(posedge clk) begin
    b1.data_a <= ma[b1.row_read_a][b1.col_read_a];
    b1.data_b <= mb[b1.row_read_b][b1.col_read_b];
    b0.data_a <= ma[b0.row_read_a][b0.col_read_a];
    b0.data_b <= mb[b0.row_read_b][b0.col_read_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] row, col; logic [31:0] val; logic ovf, sticky; } wexp_t;
  typedef struct { int cyc; logic err; } dexp_t;
  wexp_t q1[$], q0[$];
  dexp_t dq1[$], dq0[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    wexp_t e;
    dexp_t d;
    if (rst) begin
      check("rst_zero", {b1.result, b1.row_write, b1.col_write, b1.result_we, b1.elem_ovf,
                         b1.ovf_sticky, b1.busy, b1.done, b1.err}, 64'd0);
    end else begin
      if (b1.result_we) begin
        if (q1.size() == 0) check("unexp_we1", 1, 0);
        else begin
          e = q1.pop_front();
          check("we1_row", b1.row_write, e.row);
          check("we1_col", b1.col_write, e.col);
          check("we1_val", b1.result, e.val);
          check("we1_ovf", {b1.elem_ovf, b1.ovf_sticky}, {e.ovf, e.sticky});
        end
      end
      if (b1.done) begin
        if (dq1.size() == 0) check("unexp_done1", 1, 0);
        else begin
          d = dq1.pop_front();
          check("done1_cyc", cyc, d.cyc);
          check("done1_err", b1.err, d.err);
          check("done1_busy", b1.busy, 0);
          check("done1_pend", q1.size(), 0);
        end
      end
      if (b0.result_we) begin
        if (q0.size() == 0) check("unexp_we0", 1, 0);
        else begin
          e = q0.pop_front();
          check("we0_val", b0.result, e.val);
          check("we0_ovf", {b0.elem_ovf, b0.ovf_sticky}, {e.ovf, e.sticky});
        end
      end
      if (b0.done) begin
        if (dq0.size() == 0) check("unexp_done0", 1, 0);
        else begin
          d = dq0.pop_front();
          check("done0_cyc", cyc, d.cyc);
          check("done0_err", b0.err, d.err);
        end
      end
    end
    if (end_req) begin
      check("left_we1", q1.size(), 0);
      check("left_we0", q0.size(), 0);
      check("left_done1", dq1.size(), 0);
      check("left_done0", dq0.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic pw(input int d, input int r, input int c, input logic [31:0] v,
                    input logic o, input logic s);
    wexp_t e;
    e.row = r[3:0]; e.col = c[3:0]; e.val = v; e.ovf = o; e.sticky = s;
    if (d == 1) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic pd(input int d, input int c, input logic err);
    dexp_t x;
    x.cyc = c; x.err = err;
    if (d == 1) dq1.push_back(x); else dq0.push_back(x);
  endtask

  task automatic start_op(input logic [2:0] o, input int m, input int n, input int p,
                          input logic [31:0] k, input logic e0, output int t0);
    @(posedge clk); #1;
    op_r = o; dm = m[3:0]; dn = n[3:0]; dp = p[3:0]; sk = k; en0 = e0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; en0 = 1'b0; t0 = cyc;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (b1.done) break;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic clr_mem();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        ma[r][c] = 0; mb[r][c] = 0;
      end
  endtask

  task automatic load_2x3();
    clr_mem();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = r*3 + c + 1;
        mb[r][c] = 10*(r*3 + c + 1);
      end
  endtask

  int t0;

  initial begin
    rst = 1'b1; start = 0; abort = 0; en0 = 0; end_req = 0;
    op_r = 0; dm = 0; dn = 0; dp = 0; sk = 0;
    clr_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // add 2x3
    load_2x3();
    pw(1,0,0,11,0,0); pw(1,0,1,22,0,0); pw(1,0,2,33,0,0);
    pw(1,1,0,44,0,0); pw(1,1,1,55,0,0); pw(1,1,2,66,0,0);
    start_op(3'd1, 2, 3, 0, 0, 0, t0); pd(1, t0+13, 0);
    wait_done();

    // matrix multiply 2x2 * 2x2
    clr_mem();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    pw(1,0,0,19,0,0); pw(1,0,1,22,0,0); pw(1,1,0,43,0,0); pw(1,1,1,50,0,0);
    start_op(3'd3, 2, 2, 2, 0, 0, t0); pd(1, t0+17, 0);
    wait_done();

    // scalar multiply overflow: saturating DUT and wrapping DUT together
    clr_mem();
    ma[0][0] = 32'h4000_0000;
    pw(1,0,0,32'h7FFF_FFFF,1,1);
    pw(0,0,0,32'h0000_0000,1,1);
    start_op(3'd2, 1, 1, 0, 32'd4, 1, t0); pd(1, t0+3, 0); pd(0, t0+3, 0);
    wait_done();

    // transpose 2x3: element (i,j) lands at (j,i)
    load_2x3();
    pw(1,0,0,1,0,0); pw(1,1,0,2,0,0); pw(1,2,0,3,0,0);
    pw(1,0,1,4,0,0); pw(1,1,1,5,0,0); pw(1,2,1,6,0,0);
    start_op(3'd0, 2, 3, 0, 0, 0, t0); pd(1, t0+13, 0);
    wait_done();

    // oversized row count rejected without writes
    start_op(3'd1, 6, 1, 0, 0, 0, t0); pd(1, t0+2, 1);
    wait_done();

    // subtract and element-wise multiply on 1x1
    clr_mem();
    ma[0][0] = 7; mb[0][0] = 3;
    pw(1,0,0,4,0,0);
    start_op(3'd4, 1, 1, 0, 0, 0, t0); pd(1, t0+3, 0);
    wait_done();
    pw(1,0,0,21,0,0);
    start_op(3'd5, 1, 1, 0, 0, 0, t0); pd(1, t0+3, 0);
    wait_done();

    // abort during third EXEC of a 3x3 add
    clr_mem();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = r*3 + c + 1; mb[r][c] = 10*(r*3 + c + 1);
      end
    pw(1,0,0,11,0,0); pw(1,0,1,22,0,0);
    start_op(3'd1, 3, 3, 0, 0, 0, t0); pd(1, t0+7, 1);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done();

    // reset mid-operation: one strobe, then silence and no done
    pw(1,0,0,11,0,0);
    start_op(3'd1, 3, 3, 0, 0, 0, t0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    #1 end_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_end actual=running required=finished");
    $fatal(1, "monitor did not finish");
  end
endmodule

// File: doc/matrix_alu_p.md
MATRIX_ALU_P -- requirements
Module: matrix_alu_p

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, element width in bits (signed two's complement); DIM_W, default 4, width of dimension and index ports; MAX_ROWS, default 5, largest legal row count; MAX_COLS, default 5, largest legal column count; SAT_EN, default 1, 1 = saturate on overflow, 0 = wrap.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- abort  in  1  cancels a running operation.
- op  in  3  opcode: 0 transpose, 1 add, 2 scalar mul, 3 matrix mul, 4 subtract, 5 element-wise mul; 6 and 7 are illegal.
- dim_m, dim_n, dim_p  in  DIM_W each  matrix dimensions: A is m x n; B is m x n, or n x p for op 3.
- scalar_k  in  DATA_W  signed scalar for op 2.
- data_a, data_b  in  DATA_W each  operand read data; valid the cycle after the address is driven.
- row_read_a, col_read_a, row_read_b, col_read_b  out  DIM_W each  operand read addresses.
- row_write, col_write  out  DIM_W each  result write address.
- result  out  DATA_W  result element.
- result_we  out  1  one-cycle write strobe for result.
- elem_ovf  out  1  the element currently strobed overflowed.
- ovf_sticky  out  1  at least one element of the current operation overflowed.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last operation was rejected; valid with done.

Function
REQ-003 The state machine SHALL have four states: IDLE, ADDR, EXEC, DONE.
REQ-004 In IDLE, start=1 SHALL capture op, dims and scalar_k into internal registers, clear i/j/k, the accumulator, ovf_sticky and err, set busy, and move to ADDR.
REQ-005 Inputs SHALL be ignored outside IDLE, except abort.
REQ-006 On first entry to ADDR, an illegal op, a dimension of 0, m>MAX_ROWS or n>MAX_COLS SHALL set err and go to DONE with no writes. The same SHALL apply to op 3 with p=0 or p>MAX_COLS, and to op 0 with n>MAX_ROWS or m>MAX_COLS.
REQ-007 ADDR SHALL drive the read addresses and then enter EXEC:
- ops 0, 1, 2, 4, 5: A=(i,j), B=(i,j);
- op 3: A=(i,k), B=(k,j).
REQ-008 EXEC SHALL compute the element from data_a and data_b:
- op 0: A, written at (j,i);
- op 1: A+B;
- op 2: A*scalar_k;
- op 4: A-B;
- op 5: A*B;
- all except op 0 written at (i,j).
REQ-009 For op 3, EXEC SHALL add A*B into an accumulator of width 2*DATA_W+DIM_W. While k+1<n it SHALL increment k and return to ADDR. Otherwise it SHALL write the accumulator plus the current product, clear the accumulator and k, and advance j/i.
REQ-010 Indices SHALL advance row-major: j up to n-1 (p-1 for op 3), then i up to m-1; after the last element the machine SHALL enter DONE.
REQ-011 Every sum, difference and product SHALL be formed at full width before narrowing.
REQ-012 A value outside the signed DATA_W range SHALL assert elem_ovf with that element's result_we and set ovf_sticky. The result SHALL be the most positive or most negative value if SAT_EN=1, otherwise the low DATA_W bits.
REQ-013 Timing SHALL be as follows, with start accepted at edge 0:
- first result_we is high after edge 2;
- element ops strobe once every 2 cycles;
- op 3 strobes once every 2n cycles;
- done is high for exactly one cycle, the cycle after the last strobe;
- busy falls in the same cycle done rises;
- DONE returns to IDLE unconditionally.
REQ-014 abort=1 in ADDR or EXEC SHALL cause no further writes and go to DONE with err=1. abort in IDLE or DONE SHALL have no effect.
REQ-015 start held high through DONE SHALL start a new operation only once IDLE is re-entered.
REQ-016 ovf_sticky and err SHALL hold until the next accepted start.

Reset
REQ-017 rst=1 SHALL immediately force state IDLE and set every output, index, accumulator and captured register to 0.
REQ-018 A reset during an operation SHALL abandon it with no further result_we and no done pulse.

Structure
REQ-019 Opcode constants, state encodings and default MAX_ROWS/MAX_COLS SHALL live in the shared parameters include.
REQ-020 Saturation/narrowing SHALL be one combinational sub-module, sat_narrow, parametrised by input width, DATA_W and SAT_EN, producing the value and an overflow flag. Everything else SHALL stay in matrix_alu_p.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- op 1, 2x3, A=1..6, B=10..60 -> six strobes (0,0)=11 … (1,2)=66, done at cycle 13, err=0.
- op 3, A 2x2 [[1,2],[3,4]], B [[5,6],[7,8]] -> writes 19,22,43,50, done after 17 cycles.
- op 2, SAT_EN=1, A=0x40000000, k=4 -> result 0x7FFFFFFF, elem_ovf=1, ovf_sticky=1. With SAT_EN=0 -> result 0x00000000.
- op 0, 2x3 -> element (0,2) written at (2,0). Also dim_m=6 -> err=1, zero strobes, done after edge 2.
- op 4 and op 5 on a 1x1 element (7,3) -> results 4 and 21.
- abort during the 3rd EXEC of a 3x3 add -> no strobe after it, done with err=1. rst mid-op -> all outputs 0 and no done.
